// File: rtl/sm_reg_uart_dump.sv
// rtl/sm_reg_uart_dump.sv - register-file dump over UART 8N1 as ASCII hex lines
// Each register becomes "II:WWWWWWWW\r\n"; frames go back to back within a line.
module sm_reg_uart_dump #(
  parameter int BAUD_DIV  = 434,
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy
);

  localparam int            BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [4:0]    ADDR_LAST = 5'(REG_COUNT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_SEND, S_NEXT} state_t;

  state_t        r_state, w_state_nxt;
  logic [4:0]    r_addr, w_addr_nxt;
  logic [31:0]   r_word, w_word_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [3:0]    r_chr, w_chr_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_busy, w_busy_nxt;
  logic [7:0]    w_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    w_char = 8'h00;
    case (r_chr)
      4'd0:    w_char = hex_ascii({3'b000, r_addr[4]});
      4'd1:    w_char = hex_ascii(r_addr[3:0]);
      4'd2:    w_char = 8'h3A;
      4'd3:    w_char = hex_ascii(r_word[31:28]);
      4'd4:    w_char = hex_ascii(r_word[27:24]);
      4'd5:    w_char = hex_ascii(r_word[23:20]);
      4'd6:    w_char = hex_ascii(r_word[19:16]);
      4'd7:    w_char = hex_ascii(r_word[15:12]);
      4'd8:    w_char = hex_ascii(r_word[11:8]);
      4'd9:    w_char = hex_ascii(r_word[7:4]);
      4'd10:   w_char = hex_ascii(r_word[3:0]);
      4'd11:   w_char = 8'h0D;
      4'd12:   w_char = 8'h0A;
      default: w_char = 8'h00;
    endcase
  end

  // tx is computed one cycle ahead so the pin comes straight from a flop
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_word_nxt  = r_word;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_chr_nxt   = r_chr;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (start) begin
          w_state_nxt = S_SETTLE;
          w_addr_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SETTLE: w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        w_word_nxt  = regData;
        w_state_nxt = S_SEND;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
        w_chr_nxt   = '0;
        w_tx_nxt    = 1'b0;
      end
      S_SEND: begin
        if (r_baud != BAUD_LAST) begin
          w_baud_nxt = r_baud + BW'(1);
        end else begin
          w_baud_nxt = '0;
          if (r_bit != 4'd9) begin
            w_bit_nxt = r_bit + 4'd1;
            w_tx_nxt  = (r_bit == 4'd8) ? 1'b1 : w_char[r_bit[2:0]];
          end else if (r_chr != 4'd12) begin
            w_bit_nxt = '0;
            w_chr_nxt = r_chr + 4'd1;
            w_tx_nxt  = 1'b0;
          end else begin
            w_bit_nxt   = '0;
            w_chr_nxt   = '0;
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (r_addr == ADDR_LAST) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_addr_nxt  = r_addr + 5'd1;
          w_state_nxt = S_SETTLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_word  <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_chr   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_word  <= w_word_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_chr   <= w_chr_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign regAddr = r_addr;
  assign tx      = r_tx;
  assign busy    = r_busy;

endmodule

// File: tb/tb_sm_reg_uart_dump.sv
// tb/tb_sm_reg_uart_dump.sv - self-checking bench for sm_reg_uart_dump
// Instance a dumps 32 registers from a random array, instance b dumps one register.
module tb_sm_reg_uart_dump;

  localparam int BD    = 4;
  localparam int LIMIT = 40000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [4:0]  regAddr_a, regAddr_b;
  logic [31:0] regData_a, data_b = 32'h0;
  logic        tx_a, tx_b, busy_a, busy_b;
  logic [31:0] mem [32];
  longint      cyc = 0;
  int          n_chk = 0, n_err = 0, ferr = 0;

  typedef struct { int u; logic [7:0] b; longint t; } rx_t;
  rx_t    rx_q[$];
  longint t_q[$];

  typedef struct { logic [31:0] data; string line; int busy_len; } vec_t;
  vec_t vecs [4];

  assign regData_a = mem[regAddr_a];

  sm_reg_uart_dump #(.BAUD_DIV(BD), .REG_COUNT(32)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .regAddr(regAddr_a),
    .regData(regData_a), .tx(tx_a), .busy(busy_a));

  sm_reg_uart_dump #(.BAUD_DIV(BD), .REG_COUNT(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .regAddr(regAddr_b),
    .regData(data_b), .tx(tx_b), .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-bit UART receiver for both tx lines; aborts on reset.
  initial begin
    bit         act [2];
    int         c [2];
    logic [7:0] sh [2];
    logic       v;
    int         k;
    act[0] = 0; act[1] = 0;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        v = (u == 0) ? tx_a : tx_b;
        if (rst) begin
          act[u] = 0;
        end else if (!act[u]) begin
          if (v == 1'b0) begin
            act[u] = 1; c[u] = 0;
          end
        end else begin
          c[u]++;
          if (c[u] % BD == BD / 2) begin
            k = c[u] / BD;
            if (k == 0) begin
              if (v != 1'b0) begin ferr++; act[u] = 0; end
            end else if (k <= 8) begin
              sh[u][k-1] = v;
            end else begin
              if (v != 1'b1) ferr++;
              rx_q.push_back('{u: u, b: sh[u], t: cyc - longint'(c[u])});
              act[u] = 0;
            end
          end
        end
      end
    end
  end

  function automatic string hexs(input logic [31:0] v, input int nd);
    string digits = "0123456789ABCDEF";
    string r = "";
    for (int i = nd - 1; i >= 0; i--) r = $sformatf("%s%c", r, digits[int'((v >> (4 * i)) & 32'hF)]);
    return r;
  endfunction

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = $sformatf("%s%c", r, (s[i] < 8'h20) ? 8'h2E : s[i]);
    return r;
  endfunction

  function automatic string clip(input string s, input int p);
    if (p >= s.len()) return "";
    return s.substr(p, (p + 15 < s.len()) ? p + 15 : s.len() - 1);
  endfunction

  task automatic chk_int(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    int p;
    n_chk++;
    if (act != exp) begin
      n_err++;
      p = 0;
      while (p < act.len() && p < exp.len() && act[p] == exp[p]) p++;
      $display("FAIL %s: at char %0d got \"%s\" (len %0d) expected \"%s\" (len %0d)",
               name, p, vis(clip(act, p)), act.len(), vis(clip(exp, p)), exp.len());
    end
  endtask

  task automatic take(input int u, output string s);
    rx_t keep[$];
    s = "";
    t_q.delete();
    foreach (rx_q[i]) begin
      if (rx_q[i].u == u) begin
        s = $sformatf("%s%c", s, rx_q[i].b);
        t_q.push_back(rx_q[i].t);
      end else begin
        keep.push_back(rx_q[i]);
      end
    end
    rx_q = keep;
  endtask

  // One start pulse, then count busy cycles; optional second pulse and data change mid-dump.
  task automatic run_dump(input int u, input int pulse_at, input logic [31:0] alt, output int bc);
    bit done;
    @(negedge clk);
    if (u == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0; start_b = 1'b0;
    bc = 0; done = 0;
    for (int i = 0; i < LIMIT && !done; i++) begin
      @(negedge clk);
      if (((u == 0) ? busy_a : busy_b) == 1'b1) bc++;
      else if (bc > 0) done = 1;
      if (u == 0) start_a = (bc == pulse_at);
      if (u == 1 && bc == 30) data_b = alt;
    end
    start_a = 1'b0;
    if (!done) bc = -1;
  endtask

  initial begin
    string  s, exp_s;
    int     bc, gap_bad, waited;
    logic [41:0] samp, exp_samp;
    logic [9:0]  bits0;

    vecs[0] = '{32'hDEADBEEF, "00:DEADBEEF\r\n", 523};
    vecs[1] = '{32'h00000000, "00:00000000\r\n", 523};
    vecs[2] = '{32'hFFFFFFFF, "00:FFFFFFFF\r\n", 523};
    vecs[3] = '{32'h9A5C0F37, "00:9A5C0F37\r\n", 523};
    for (int i = 0; i < 32; i++) mem[i] = $urandom;

    #1 rst = 1'b1;
    #1;
    chk_int("reset_tx", tx_a, 1);
    chk_int("reset_busy", busy_a, 0);
    chk_int("reset_addr", regAddr_a, 0);
    chk_int("reset_addr_b", regAddr_b, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Frame of '0' (0x30): start, d0..d7 LSB first, stop.
    bits0 = 10'b1001100000;
    data_b = 32'h12345678;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      samp[i] = tx_b;
      exp_samp[i] = (i < 2) ? 1'b1 : bits0[(i - 2) / BD];
    end
    chk_int("first_frame_bits", samp, exp_samp);
    chk_int("start_bit_begins", {samp[1], samp[2]}, 2'b10);
    waited = 0;
    while (busy_b && waited < 2000) begin @(negedge clk); waited++; end
    chk_int("idle_b_after_frame", busy_b, 0);
    take(1, s);

    foreach (vecs[i]) begin
      data_b = vecs[i].data;
      run_dump(1, -1, ~vecs[i].data, bc);
      repeat (2) @(negedge clk);
      take(1, s);
      chk_str($sformatf("line_b[%0d]", i), s, vecs[i].line);
      chk_int($sformatf("busy_len_b[%0d]", i), bc, vecs[i].busy_len);
    end
    chk_int("framing_errors_b", ferr, 0);

    // Asynchronous reset mid-transfer, checked before any clock edge.
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    waited = 0;
    while (!(regAddr_a >= 5'd2 && tx_a == 1'b0) && waited < 5000) begin @(negedge clk); waited++; end
    #1 rst = 1'b1;
    #1;
    chk_int("async_rst_tx", tx_a, 1);
    chk_int("async_rst_busy", busy_a, 0);
    chk_int("async_rst_addr", regAddr_a, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    take(0, s);

    // Reset during bit 6 of character 4 of line 0, then a full random dump.
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[31] = 32'h0123ABCD;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (3 + 4 * 10 * BD + 6 * BD + 1) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_int("rst_mid_char_tx", tx_a, 1);
    chk_int("rst_mid_char_busy", busy_a, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    take(0, s);
    ferr = 0;

    run_dump(0, 5 * (3 + 13 * 10 * BD) + 100, 32'h0, bc);
    repeat (2) @(negedge clk);
    take(0, s);
    exp_s = "";
    for (int i = 0; i < 32; i++) exp_s = {exp_s, hexs(32'(i), 2), ":", hexs(mem[i], 8), "\r\n"};
    gap_bad = 0;
    for (int i = 1; i < t_q.size(); i++)
      if (t_q[i] - t_q[i-1] != ((i % 13 == 0) ? 10 * BD + 3 : 10 * BD)) gap_bad++;
    chk_int("dump_byte_count", s.len(), 32 * 13);
    chk_str("dump_first", clip(s, 0).substr(0, 2), "00:");
    chk_str("dump_text", s, exp_s);
    chk_str("dump_last_line", (s.len() >= 13) ? s.substr(s.len() - 13, s.len() - 1) : s, "1F:0123ABCD\r\n");
    chk_int("dump_gap_violations", gap_bad, 0);
    chk_int("dump_busy_len", bc, 32 * (3 + 13 * 10 * BD));
    chk_int("dump_framing_errors", ferr, 0);
    chk_int("dump_end_tx", tx_a, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
